// File: rtl/comb_pipe_pkg.sv
// -----------------------------------------------------------------------------
// comb_pipe_pkg
// Shared types and constants for the comb_pipe_select pipeline.
//   dec_e    : decision class produced by the select core and carried in
//              stage B (used to recognise key-1 results for the hit counter)
//   K1 / K3  : key values that pick the special select rules
//   make_key : assembles the 3-bit key from one bit of each operand
// -----------------------------------------------------------------------------
package comb_pipe_pkg;

  typedef enum logic [1:0] {
    DEC_GE      = 2'd0,
    DEC_LT_K1   = 2'd1,
    DEC_LT_K3   = 2'd2,
    DEC_LT_DFLT = 2'd3
  } dec_e;

  localparam logic [2:0] K1 = 3'd1;
  localparam logic [2:0] K3 = 3'd3;

  // Key bit order is {src3, src2, src1}.
  function automatic logic [2:0] make_key(input logic b1, input logic b2, input logic b3);
    return {b3, b2, b1};
  endfunction

endpackage

// File: rtl/comb_select_core.sv
// -----------------------------------------------------------------------------
// comb_select_core
// Purely combinational compare/select function.
// Ports:
//   src1, src2, src3 : operands (SIZE bits)
//   ge               : precomputed unsigned src1 >= src2
//   key              : 3-bit key {src3[b], src2[b], src1[b]}
//   out1..out5       : selected results (SIZE bits)
//   dec              : decision class for the chosen rule
// -----------------------------------------------------------------------------
module comb_select_core
  import comb_pipe_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] src1,
  input  logic [SIZE-1:0] src2,
  input  logic [SIZE-1:0] src3,
  input  logic            ge,
  input  logic [2:0]      key,
  output logic [SIZE-1:0] out1,
  output logic [SIZE-1:0] out2,
  output logic [SIZE-1:0] out3,
  output logic [SIZE-1:0] out4,
  output logic [SIZE-1:0] out5,
  output dec_e            dec
);

  // Select the five results and the decision class from compare and key.
  always_comb begin
    out1 = src1;
    out2 = src2;
    out3 = src1;
    out4 = src2;
    out5 = src1;
    dec  = DEC_GE;
    if (ge) begin
      out1 = src1;
      out2 = src2;
      out3 = src1;
      out4 = src2;
      out5 = src1;
      dec  = DEC_GE;
    end else begin
      case (key)
        K1: begin
          out1 = src3;
          out2 = src3;
          out3 = src2;
          out4 = src3;
          out5 = src3;
          dec  = DEC_LT_K1;
        end
        K3: begin
          out1 = src1;
          out2 = src2;
          out3 = {SIZE{1'b0}};
          out4 = {SIZE{1'b0}};
          out5 = src3;
          dec  = DEC_LT_K3;
        end
        default: begin
          out1 = src1;
          out2 = src2;
          out3 = src2;
          out4 = src1;
          out5 = src3;
          dec  = DEC_LT_DFLT;
        end
      endcase
    end
  end

endmodule

// File: rtl/comb_pipe_select.sv
// -----------------------------------------------------------------------------
// comb_pipe_select
// Two-stage valid/ready pipeline around comb_select_core, with a saturating
// counter of delivered key-1 results.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (accept = in_valid && in_ready)
//   key_sel             : 0 -> key from bit 0, 1 -> key from bit SIZE-1
//   src1..src3          : operands, sampled on accept
//   out_valid/out_ready : output handshake (delivery = out_valid && out_ready)
//   out1..out5          : registered results, stable while stalled
//   hit_clr             : synchronous clear of hit_cnt (wins over increment)
//   hit_cnt             : saturating count of delivered key-1 results
// -----------------------------------------------------------------------------
module comb_pipe_select
  import comb_pipe_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             key_sel,
  input  logic [SIZE-1:0]  src1,
  input  logic [SIZE-1:0]  src2,
  input  logic [SIZE-1:0]  src3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out1,
  output logic [SIZE-1:0]  out2,
  output logic [SIZE-1:0]  out3,
  output logic [SIZE-1:0]  out4,
  output logic [SIZE-1:0]  out5,
  input  logic             hit_clr,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  // Stage A state
  logic            a_valid_q, a_valid_d;
  logic [SIZE-1:0] a_src1_q, a_src1_d, a_src2_q, a_src2_d, a_src3_q, a_src3_d;
  logic            a_ge_q, a_ge_d;
  logic [2:0]      a_key_q, a_key_d;

  // Stage B state
  logic            b_valid_q, b_valid_d;
  logic [SIZE-1:0] out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic [SIZE-1:0] out4_q, out4_d, out5_q, out5_d;
  dec_e            b_dec_q, b_dec_d;

  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  // Core outputs and flow control
  logic [SIZE-1:0] core_out1, core_out2, core_out3, core_out4, core_out5;
  dec_e            core_dec;
  logic [2:0]      key_in;
  logic            b_load, a_load, deliver;

  // B may load when empty or when its current result leaves this cycle;
  // A may load when empty or when its content moves into B.
  assign deliver   = b_valid_q & out_ready;
  assign b_load    = ~b_valid_q | out_ready;
  assign a_load    = ~a_valid_q | b_load;
  assign in_ready  = a_load;
  assign out_valid = b_valid_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out3      = out3_q;
  assign out4      = out4_q;
  assign out5      = out5_q;
  assign hit_cnt   = hit_cnt_q;

  // Key extraction from the bit chosen by key_sel (both are bit 0 when SIZE=1).
  always_comb begin
    key_in = 3'd0;
    if (key_sel) begin
      key_in = make_key(src1[SIZE-1], src2[SIZE-1], src3[SIZE-1]);
    end else begin
      key_in = make_key(src1[0], src2[0], src3[0]);
    end
  end

  // Stage A next state: capture operands, compare and key on accept.
  always_comb begin
    a_valid_d = a_valid_q;
    a_src1_d  = a_src1_q;
    a_src2_d  = a_src2_q;
    a_src3_d  = a_src3_q;
    a_ge_d    = a_ge_q;
    a_key_d   = a_key_q;
    if (a_load) begin
      a_valid_d = in_valid;
      if (in_valid) begin
        a_src1_d = src1;
        a_src2_d = src2;
        a_src3_d = src3;
        a_ge_d   = (src1 >= src2);
        a_key_d  = key_in;
      end else begin
        a_src1_d = a_src1_q;
      end
    end else begin
      a_valid_d = a_valid_q;
    end
  end

  comb_select_core #(.SIZE(SIZE)) u_core (
    .src1 (a_src1_q),
    .src2 (a_src2_q),
    .src3 (a_src3_q),
    .ge   (a_ge_q),
    .key  (a_key_q),
    .out1 (core_out1),
    .out2 (core_out2),
    .out3 (core_out3),
    .out4 (core_out4),
    .out5 (core_out5),
    .dec  (core_dec)
  );

  // Stage B next state: results only change when B reloads with valid data,
  // so they hold while stalled.
  always_comb begin
    b_valid_d = b_valid_q;
    out1_d    = out1_q;
    out2_d    = out2_q;
    out3_d    = out3_q;
    out4_d    = out4_q;
    out5_d    = out5_q;
    b_dec_d   = b_dec_q;
    if (b_load) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        out1_d  = core_out1;
        out2_d  = core_out2;
        out3_d  = core_out3;
        out4_d  = core_out4;
        out5_d  = core_out5;
        b_dec_d = core_dec;
      end else begin
        b_dec_d = b_dec_q;
      end
    end else begin
      b_valid_d = b_valid_q;
    end
  end

  // Hit counter: clear has priority, increments saturate at all-ones.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (hit_clr) begin
      hit_cnt_d = {CNT_W{1'b0}};
    end else if (deliver && (b_dec_q == DEC_LT_K1) && (hit_cnt_q != CNT_MAX)) begin
      hit_cnt_d = hit_cnt_q + CNT_ONE;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Stage A registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_src1_q  <= {SIZE{1'b0}};
      a_src2_q  <= {SIZE{1'b0}};
      a_src3_q  <= {SIZE{1'b0}};
      a_ge_q    <= 1'b0;
      a_key_q   <= 3'd0;
    end else begin
      a_valid_q <= a_valid_d;
      a_src1_q  <= a_src1_d;
      a_src2_q  <= a_src2_d;
      a_src3_q  <= a_src3_d;
      a_ge_q    <= a_ge_d;
      a_key_q   <= a_key_d;
    end
  end

  // Stage B registers and hit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      out1_q    <= {SIZE{1'b0}};
      out2_q    <= {SIZE{1'b0}};
      out3_q    <= {SIZE{1'b0}};
      out4_q    <= {SIZE{1'b0}};
      out5_q    <= {SIZE{1'b0}};
      b_dec_q   <= DEC_GE;
      hit_cnt_q <= {CNT_W{1'b0}};
    end else begin
      b_valid_q <= b_valid_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
      out3_q    <= out3_d;
      out4_q    <= out4_d;
      out5_q    <= out5_d;
      b_dec_q   <= b_dec_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

endmodule

// File: tb/tb_comb_pipe_select.sv
// -----------------------------------------------------------------------------
// tb_comb_pipe_select
// Self-checking bench for comb_pipe_select (SIZE=4, CNT_W=2). A queue of
// expected results, stamped with the clock edge at which each was accepted,
// predicts in_ready, out_valid, out1..out5 and hit_cnt every cycle.
// -----------------------------------------------------------------------------
module tb_comb_pipe_select;

  localparam int SIZE    = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             key_sel = 1'b0;
  logic [SIZE-1:0]  src1 = '0, src2 = '0, src3 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SIZE-1:0]  out1, out2, out3, out4, out5;
  logic             hit_clr = 1'b0;
  logic [CNT_W-1:0] hit_cnt;

  always #5 clk = ~clk;

  comb_pipe_select #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_sel   (key_sel),
    .src1      (src1),
    .src2      (src2),
    .src3      (src3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .hit_clr   (hit_clr),
    .hit_cnt   (hit_cnt)
  );

  typedef struct {
    logic [SIZE-1:0] o1, o2, o3, o4, o5;
    bit              hit;
    int              stamp;
  } exp_t;

  exp_t q[$];
  int   edges     = 0;
  int   model_cnt = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   acc_seen  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference rules written straight from the functional description.
  function automatic exp_t ref_model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                     input logic [SIZE-1:0] c, input logic ks);
    exp_t       r;
    int         bi;
    logic [2:0] k;
    bi = ks ? SIZE - 1 : 0;
    k  = {c[bi], b[bi], a[bi]};
    r.hit   = 1'b0;
    r.stamp = 0;
    if (a >= b) begin
      r.o1 = a; r.o2 = b; r.o3 = a; r.o4 = b; r.o5 = a;
    end else if (k == 3'd1) begin
      r.o1 = c; r.o2 = c; r.o3 = b; r.o4 = c; r.o5 = c; r.hit = 1'b1;
    end else if (k == 3'd3) begin
      r.o1 = a; r.o2 = b; r.o3 = '0; r.o4 = '0; r.o5 = c;
    end else begin
      r.o1 = a; r.o2 = b; r.o3 = b; r.o4 = a; r.o5 = c;
    end
    return r;
  endfunction

  // One cycle: drive at the falling edge, check, advance the model, clock.
  task automatic step(input logic iv, input logic ks, input logic [SIZE-1:0] a,
                      input logic [SIZE-1:0] b, input logic [SIZE-1:0] c,
                      input logic ordy, input logic clr);
    exp_t e;
    logic exp_ready, exp_valid;
    in_valid = iv; key_sel = ks; src1 = a; src2 = b; src3 = c;
    out_ready = ordy; hit_clr = clr;
    #1;
    exp_ready = (q.size() < 2) || ordy;
    exp_valid = (q.size() > 0) && ((edges - q[0].stamp) >= 1);
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
    check_eq("hit_cnt", 32'(hit_cnt), 32'(model_cnt));
    if (exp_valid) begin
      check_eq("out1", 32'(out1), 32'(q[0].o1));
      check_eq("out2", 32'(out2), 32'(q[0].o2));
      check_eq("out3", 32'(out3), 32'(q[0].o3));
      check_eq("out4", 32'(out4), 32'(q[0].o4));
      check_eq("out5", 32'(out5), 32'(q[0].o5));
    end
    if (iv && in_ready) acc_seen++;
    if (exp_valid && ordy) begin
      e = q.pop_front();
      if (clr) model_cnt = 0;
      else if (e.hit && model_cnt < CNT_TOP) model_cnt++;
    end else if (clr) begin
      model_cnt = 0;
    end
    if (iv && exp_ready) begin
      e = ref_model(a, b, c, ks);
      e.stamp = edges + 1;
      q.push_back(e);
    end
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check_eq("rst_out1", 32'(out1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    edges = 0;

    // Directed vectors, back to back.
    step(1'b1, 1'b0, 4'd2, 4'd5, 4'd7, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd1, 4'd6, 4'd8, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'd8, 4'd9, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd9, 4'd9, 4'd2, 1'b1, 1'b0);
    idle(3);
    check_eq("hit_after_k1", 32'(hit_cnt), 32'd1);

    // Clear, then five key-1 deliveries saturate at 3.
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd1, 4'd6, 4'd8, 1'b1, 1'b0);
    idle(3);
    check_eq("hit_saturated", 32'(hit_cnt), 32'd3);

    // Clear coinciding with a key-1 delivery.
    step(1'b1, 1'b0, 4'd1, 4'd6, 4'd8, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    check_eq("clr_wins", 32'(hit_cnt), 32'd0);

    // Randomised traffic with random backpressure and clears.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           4'($urandom), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end
    idle(4);

    // Backpressure: only two accepts while out_ready stays low.
    acc_seen = 0;
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 4'd1, 4'(2 * i + 2), 4'(2 * i), 1'b0, 1'b0);
    check_eq("bp_accepts", 32'(acc_seen), 32'd2);
    idle(4);

    // Fill both stages, then reset mid-stream.
    step(1'b1, 1'b0, 4'd1, 4'd6, 4'd8, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd3, 4'd2, 4'd5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
    check_eq("midrst_out1", 32'(out1), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    model_cnt = 0;
    @(posedge clk);
    edges++;
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comb_pipe_select.md
Name: comb_pipe_select

Overview:
- Registered, flow-controlled successor to the team's combinational compare/select test block.
- Computes the same five-output compare/case function on three SIZE-bit operands, behind a 2-stage valid/ready pipeline.
- Adds a selectable key-bit position and a saturating counter of key-1 hits.
- Used as a sequential systest target for always_ff, enum and handshake translation, instantiated at several SIZE values.

Parameters:
- SIZE, 4, operand/result width in bits (>=1)
- CNT_W, 8, width of hit counter (>=1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept operands this cycle
- key_sel  input  1  0: key uses bit 0 of each operand; 1: key uses bit SIZE-1
- src1, src2, src3  input  SIZE  operands, sampled on accept
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result this cycle
- out1..out5  output  SIZE each  results
- hit_clr  input  1  synchronous clear of hit_cnt
- hit_cnt  output  CNT_W  count of delivered key-1 results, saturating

Behaviour:
- Accept occurs when in_valid && in_ready. Delivery occurs when out_valid && out_ready.
- key = {src3[b], src2[b], src1[b]}, where b = 0 when key_sel=0 and b = SIZE-1 when key_sel=1. For SIZE=1 both settings select bit 0.
- Function, all comparisons unsigned, all results SIZE bits:
  - src1 >= src2: out1=src1, out2=src2, out3=src1, out4=src2, out5=src1.
  - src1 < src2, key==1: out1=out2=out4=src3, out3=src2, out5=src3.
  - src1 < src2, key==3: out1=src1, out2=src2, out3=0, out4=0, out5=src3.
  - src1 < src2, any other key: out1=src1, out2=src2, out3=src2, out4=src1, out5=src3.
- Stage A registers operands, the compare result and key.
- Stage B registers out1..out5 plus a decision class.
- Latency: result is visible on out_valid 2 cycles after accept.
- Throughput: 1 per cycle while out_ready=1.
- Stage B loads when it is empty or delivering. Stage A loads when it is empty or moving into B.
- in_ready = !a_valid || !b_valid || out_ready.
  - No combinational path from in_valid to in_ready.
  - A path from out_ready to in_ready is permitted.
- While out_valid=1 && out_ready=0, out1..out5 hold stable.
- Ordering is strictly FIFO; no result is dropped or duplicated.
- hit_cnt increments on delivery of a key-1 result and saturates at 2^CNT_W-1.
  - If hit_clr and an increment occur in the same cycle, clear wins and the result is 0.
- Reset (any cycle, including mid-stream): a_valid=b_valid=0, out_valid=0, out1..out5=0, hit_cnt=0 immediately. in_ready=1 after reset.
- key_sel is sampled per transaction. Changing it does not affect in-flight results.

Decomposition:
- Package comb_pipe_pkg holds:
  - enum dec_e {DEC_GE, DEC_LT_K1, DEC_LT_K3, DEC_LT_DFLT}
  - localparam key values K1=3'd1 and K3=3'd3
- One sub-module, comb_select_core: purely combinational. Maps (src1, src2, src3, key) to out1..out5 plus dec_e. Parametrised by SIZE. Instantiated between stage A and stage B.

Test Plan:
- SIZE=4, key_sel=0, src1=2, src2=5, src3=7 (key=6) -> 2 cycles later: out1=2, out2=5, out3=5, out4=2, out5=7; hit_cnt unchanged.
- SIZE=4, key_sel=0, src1=1, src2=6, src3=8 (key=1) -> out1=out2=out4=8, out3=6, out5=8; hit_cnt 0->1 on delivery.
- SIZE=4, key_sel=1, src1=8, src2=9, src3=0 (key=3 via bit 3) -> out1=8, out2=9, out3=0, out4=0, out5=0.
- SIZE=4, src1=9, src2=9, src3=2 -> all five outputs = 9.
- Backpressure check:
  - Stimulus: out_ready=0 for 5 cycles, in_valid=1 with distinct operand sets.
  - Expected: exactly 2 accepts, then in_ready=0; outputs stable throughout.
  - Release: raise out_ready; results emerge in order, one per cycle.
- CNT_W=2, five key-1 deliveries -> hit_cnt=3. hit_clr coinciding with a hit -> 0. Assert rst with both stages full -> out_valid=0 and hit_cnt=0 the same cycle, with no delivery after release.
